// File: rtl/muldiv_iter_if.sv
// Request/response bundle of the iterative multiply/divide unit.
interface muldiv_iter_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (output flush, in_valid, op, a, b, out_ready,
                  input  in_ready, out_valid, result, busy);
  modport slave  (input  flush, in_valid, op, a, b, out_ready,
                  output in_ready, out_valid, result, busy);
endinterface

// File: rtl/muldiv_iter.sv
// Radix-2 iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes.
// One shared 2*XLEN register holds {hi, multiplier} for multiply or {remainder, quotient} for divide.
module muldiv_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_iter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_e;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [XLEN-1:0]   ZERO_X   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONES_X   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   MIN_X    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept_s, is_div_s, sa_s, sb_s, neg_s, div0_s, ovf_s, fast_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s, fast_res_s;
  logic [XLEN:0]     mul_sum_s, div_trial_s, div_diff_s;
  logic [2*XLEN-1:0] mul_step_s, div_step_s, step_s, prod_fix_s;
  logic [XLEN-1:0]   div_sel_s, div_fix_s, fin_res_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      neg_q    <= 1'b0;
      cnt_q    <= CNT_ZERO;
      acc_q    <= {(2*XLEN){1'b0}};
      opnd_q   <= ZERO_X;
      result_q <= ZERO_X;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
    end
  end

  // Request decode: signs, magnitudes, negate flag and early-completing division cases.
  always_comb begin
    accept_s = (state_q == S_IDLE) && bus.in_valid && !bus.flush;
    is_div_s = bus.op[2];
    sa_s     = bus.a[XLEN-1] && ((bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                                 (bus.op == OP_DIV)  || (bus.op == OP_REM));
    sb_s     = bus.b[XLEN-1] && ((bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM));
    a_mag_s  = sa_s ? (~bus.a + ONE_X) : bus.a;
    b_mag_s  = sb_s ? (~bus.b + ONE_X) : bus.b;
    case (bus.op)
      OP_MULH, OP_DIV:   neg_s = sa_s ^ sb_s;
      OP_MULHSU, OP_REM: neg_s = sa_s;
      default:           neg_s = 1'b0;
    endcase
    div0_s = is_div_s && (bus.b == ZERO_X);
    ovf_s  = is_div_s && !bus.op[0] && (bus.a == MIN_X) && (bus.b == ONES_X);
    fast_s = div0_s || ovf_s;
    if (div0_s) begin
      fast_res_s = bus.op[1] ? bus.a : ONES_X;
    end else begin
      fast_res_s = bus.op[1] ? ZERO_X : bus.a;
    end
  end

  // One shift-add or restoring-subtract step, plus sign fix-up and result select for the last step.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_step_s  = {mul_sum_s, acc_q[XLEN-1:1]};
    div_trial_s = acc_q[2*XLEN-1:XLEN-1];
    div_diff_s  = div_trial_s - {1'b0, opnd_q};
    if (div_diff_s[XLEN]) begin
      div_step_s = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      div_step_s = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
    step_s     = op_q[2] ? div_step_s : mul_step_s;
    prod_fix_s = neg_q ? (~step_s + ONE_2X) : step_s;
    div_sel_s  = op_q[1] ? step_s[2*XLEN-1:XLEN] : step_s[XLEN-1:0];
    div_fix_s  = neg_q ? (~div_sel_s + ONE_X) : div_sel_s;
    if (op_q[2]) begin
      fin_res_s = div_fix_s;
    end else begin
      fin_res_s = (op_q == OP_MUL) ? prod_fix_s[XLEN-1:0] : prod_fix_s[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = bus.in_valid ? (fast_s ? S_DONE : S_CALC) : S_IDLE;
        S_CALC:  state_d = (cnt_q == CNT_ZERO) ? S_DONE : S_CALC;
        S_DONE:  state_d = bus.out_ready ? S_IDLE : S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Register updates; result_q is zero outside DONE so the output needs no gating.
  always_comb begin
    op_d   = op_q;
    neg_d  = neg_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    if (accept_s) begin
      op_d   = bus.op;
      neg_d  = neg_s;
      cnt_d  = CNT_LAST;
      acc_d  = {ZERO_X, (is_div_s ? a_mag_s : b_mag_s)};
      opnd_d = is_div_s ? b_mag_s : a_mag_s;
    end else if (state_q == S_CALC) begin
      acc_d = step_s;
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      acc_d = acc_q;
    end
    if (state_d != S_DONE) begin
      result_d = ZERO_X;
    end else if (state_q == S_IDLE) begin
      result_d = fast_res_s;
    end else if (state_q == S_CALC) begin
      result_d = fin_res_s;
    end else begin
      result_d = result_q;
    end
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
    bus.busy      = (state_q != S_IDLE);
    bus.result    = result_q;
  end

endmodule
